// File: rtl/clock_set_ctrl.sv
// Time-set sequencer for the HH:MM:SS clock. It debounces the MODE and INC
// keys and steps through the set states. It also issues one-cycle inc/clear
// strobes to the selected field counter and blinks the field being edited.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | clock counts normally, keys other than MODE are ignored
//   SET_HOUR | count frozen, INC (and auto-repeat) bumps hours
//   SET_MIN  | count frozen, INC (and auto-repeat) bumps minutes
//   SET_SEC  | count frozen, INC clears seconds
module clock_set_ctrl #(
  parameter int DB_CYC        = 1_000_000,
  parameter int RPT_DLY_CYC   = 25_000_000,
  parameter int RPT_CYC       = 10_000_000,
  parameter int BLINK_CYC     = 12_500_000,
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic       tick_1hz,
  output logic       run_en,
  output logic       sec_inc,
  output logic       sec_clr,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       blank_hour,
  output logic       blank_min,
  output logic       blank_sec,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam int DB_W    = $clog2(DB_CYC + 1);
  localparam int RPT_MAX = (RPT_DLY_CYC > RPT_CYC) ? RPT_DLY_CYC : RPT_CYC;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int BLK_W   = $clog2(BLINK_CYC + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [DB_W-1:0]   DB_RELOAD  = DB_W'(DB_CYC - 1);
  localparam logic [RPT_W-1:0]  RPT_FIRST  = RPT_W'(RPT_DLY_CYC - 1);
  localparam logic [RPT_W-1:0]  RPT_NEXT   = RPT_W'(RPT_CYC - 1);
  localparam logic [BLK_W-1:0]  BLK_RELOAD = BLK_W'(BLINK_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD  = IDLE_W'(TIMEOUT_TICKS);

  // Button index 0 = MODE, 1 = INC. All internal levels are active-high "pressed".
  logic [1:0]            raw_pressed;
  logic [1:0]            sync1, sync2;
  logic [1:0]            db_lvl;
  logic [1:0]            armed;
  logic [1:0]            press_ev;
  logic [1:0][DB_W-1:0]  db_cnt;

  state_t                state_q, state_d;
  logic                  in_set, rpt_state, state_chg;
  logic                  mode_ev, inc_ev, inc_lvl;
  logic                  rpt_on, rpt_fire, timeout, strobe_en;
  logic                  hour_d, min_d, clr_d;
  logic [RPT_W-1:0]      rpt_cnt;
  logic [IDLE_W-1:0]     idle_left;
  logic [BLK_W-1:0]      blink_cnt;
  logic                  blink_phase;

  assign raw_pressed = {~btn_inc_n, ~btn_mode_n};

  // Two-flop synchroniser. It resets to "pressed" so that the first samples
  // after reset cannot arm a key that is physically held.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= raw_pressed;
      sync2 <= sync1;
    end
  end

  // Debounce: a down-counter accepts a new level after DB_CYC consecutive
  // differing samples. Press events only fire once the key has been seen
  // released, which swallows a key held across reset. Needs DB_CYC >= 3.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      db_lvl   <= 2'b00;
      armed    <= 2'b00;
      press_ev <= 2'b00;
      db_cnt   <= {2{DB_RELOAD}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        press_ev[i] <= 1'b0;
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= DB_RELOAD;
        end else if (db_cnt[i] == '0) begin
          db_lvl[i]   <= sync2[i];
          db_cnt[i]   <= DB_RELOAD;
          press_ev[i] <= sync2[i] & armed[i];
        end else begin
          db_cnt[i] <= db_cnt[i] - DB_W'(1);
        end
        if (!db_lvl[i] && !sync2[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign mode_ev   = press_ev[0];
  assign inc_ev    = press_ev[1];
  assign inc_lvl   = db_lvl[1];
  assign in_set    = (state_q != RUN);
  assign rpt_state = (state_q == SET_HOUR) || (state_q == SET_MIN);
  assign rpt_fire  = rpt_state && rpt_on && inc_lvl && (rpt_cnt == '0);
  assign timeout   = in_set && tick_1hz && (idle_left == IDLE_W'(1));

  // Next state and strobe selection. Timeout beats MODE, and MODE beats INC.
  always_comb begin
    state_d   = state_q;
    strobe_en = 1'b0;
    if (timeout) begin
      state_d = RUN;
    end else if (mode_ev) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        SET_SEC:  state_d = RUN;
      endcase
    end else if (in_set && (inc_ev || rpt_fire)) begin
      strobe_en = 1'b1;
    end
    hour_d = strobe_en && (state_q == SET_HOUR);
    min_d  = strobe_en && (state_q == SET_MIN);
    clr_d  = strobe_en && (state_q == SET_SEC);
  end

  assign state_chg = (state_d != state_q);

  // State register and registered one-cycle strobes.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      hour_inc <= 1'b0;
      min_inc  <= 1'b0;
      sec_clr  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hour_inc <= hour_d;
      min_inc  <= min_d;
      sec_clr  <= clr_d;
    end
  end

  // Auto-repeat timer. It is armed only by a real INC press in an hour or minute
  // set state and is dropped by release, MODE or any state change.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rpt_on  <= 1'b0;
      rpt_cnt <= '0;
    end else if (state_chg || mode_ev || !inc_lvl || !rpt_state) begin
      rpt_on  <= 1'b0;
      rpt_cnt <= '0;
    end else if (inc_ev) begin
      rpt_on  <= 1'b1;
      rpt_cnt <= RPT_FIRST;
    end else if (rpt_on) begin
      rpt_cnt <= (rpt_cnt == '0) ? RPT_NEXT : rpt_cnt - RPT_W'(1);
    end
  end

  // Idle timer: counts seconds down while in a set state, reloaded by any activity.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      idle_left <= IDLE_LOAD;
    end else if (!in_set || state_chg || inc_ev || mode_ev || rpt_fire) begin
      idle_left <= IDLE_LOAD;
    end else if (tick_1hz && (idle_left != '0)) begin
      idle_left <= idle_left - IDLE_W'(1);
    end
  end

  // Blink phase: restarts visible on state entry and on every strobe so that
  // the edited digits are always shown right after a change.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      blink_cnt   <= BLK_RELOAD;
      blink_phase <= 1'b0;
    end else if (!in_set || state_chg || strobe_en) begin
      blink_cnt   <= BLK_RELOAD;
      blink_phase <= 1'b0;
    end else if (blink_cnt == '0) begin
      blink_cnt   <= BLK_RELOAD;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt - BLK_W'(1);
    end
  end

  assign state      = state_q;
  assign run_en     = (state_q == RUN);
  assign sec_inc    = 1'b0;
  assign blank_hour = (state_q == SET_HOUR) & blink_phase;
  assign blank_min  = (state_q == SET_MIN)  & blink_phase;
  assign blank_sec  = (state_q == SET_SEC)  & blink_phase;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl using short timing parameters.
module tb_clock_set_ctrl;

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode_n = 1'b1;
  logic       btn_inc_n = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       run_en, sec_inc, sec_clr, min_inc, hour_inc;
  logic       blank_hour, blank_min, blank_sec;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_hour = 0, n_min = 0, n_clr = 0, n_secinc = 0, n_multi = 0;
  int hour_at[16];
  int base, n_hour0, n_min0;
  int exp_at[6] = '{7, 27, 35, 43, 51, 59};

  clock_set_ctrl #(
    .DB_CYC(4), .RPT_DLY_CYC(20), .RPT_CYC(8), .BLINK_CYC(6), .TIMEOUT_TICKS(3)
  ) dut (
    .clk50(clk50), .reset(reset), .btn_mode_n(btn_mode_n), .btn_inc_n(btn_inc_n),
    .tick_1hz(tick_1hz), .run_en(run_en), .sec_inc(sec_inc), .sec_clr(sec_clr),
    .min_inc(min_inc), .hour_inc(hour_inc), .blank_hour(blank_hour),
    .blank_min(blank_min), .blank_sec(blank_sec), .state(state)
  );

  always #10 clk50 = ~clk50;

  // Advance n cycles, sampling 1 time unit after each rising edge and tallying strobes.
  task automatic step(input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk50);
      #1;
      cyc++;
      s = int'(hour_inc) + int'(min_inc) + int'(sec_clr) + int'(sec_inc);
      if (s > 1) n_multi++;
      if (hour_inc) begin
        if (n_hour < 16) hour_at[n_hour] = cyc;
        n_hour++;
      end
      if (min_inc) n_min++;
      if (sec_clr) n_clr++;
      if (sec_inc) n_secinc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Clean press: hold 10 cycles, release, wait for release to debounce.
  task automatic press(input int which);
    if (which == 0) btn_mode_n = 1'b0; else btn_inc_n = 1'b0;
    step(10);
    if (which == 0) btn_mode_n = 1'b1; else btn_inc_n = 1'b1;
    step(10);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) hour_at[k] = -1;

    // Reset and idle
    step(3);
    chk("rst_state", state, 0);
    chk("rst_run_en", run_en, 1);
    chk("rst_hour_inc", hour_inc, 0);
    reset = 1'b0;
    step(50);
    chk("idle_state", state, 0);
    chk("idle_run_en", run_en, 1);
    chk("idle_strobes", {sec_inc, sec_clr, min_inc, hour_inc}, 0);
    chk("idle_blanks", {blank_hour, blank_min, blank_sec}, 0);
    chk("idle_strobe_cnt", n_hour + n_min + n_clr + n_secinc, 0);

    // Glitch shorter than the debounce window
    btn_mode_n = 1'b0; step(3); btn_mode_n = 1'b1; step(12);
    chk("glitch_state", state, 0);

    // Real MODE press: event after sync + debounce, state one cycle later
    btn_mode_n = 1'b0;
    step(6);
    chk("mode_before", state, 0);
    step(1);
    chk("mode_state", state, 1);
    chk("mode_run_en", run_en, 0);
    step(3);
    btn_mode_n = 1'b1;
    step(10);
    chk("mode_release", state, 1);

    // Hold INC 60 cycles in SET_HOUR: first strobe plus five repeats
    base = cyc;
    btn_inc_n = 1'b0;
    step(60);
    btn_inc_n = 1'b1;
    step(30);
    chk("hold_count", n_hour, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("hold_at%0d", k), hour_at[k] - base, exp_at[k]);
    chk("hold_min_cnt", n_min, 0);
    chk("hold_state", state, 1);

    // SET_SEC: INC clears seconds
    press(0);
    chk("to_min", state, 2);
    press(0);
    chk("to_sec", state, 3);
    press(1);
    chk("sec_clr_cnt", n_clr, 1);
    chk("sec_hour_cnt", n_hour, 6);
    chk("sec_min_cnt", n_min, 0);
    chk("sec_inc_cnt", n_secinc, 0);

    // Back round to SET_MIN, check blink cadence (entry was 13 cycles ago)
    press(0);
    chk("wrap_run", state, 0);
    press(0);
    press(0);
    chk("min_again", state, 2);
    chk("blink_e13", {blank_hour, blank_min, blank_sec}, 3'b000);
    step(5);
    chk("blink_e18", {blank_hour, blank_min, blank_sec}, 3'b010);
    step(5);
    chk("blink_e23", blank_min, 1);
    step(1);
    chk("blink_e24", blank_min, 0);
    step(6);
    chk("blink_e30", blank_min, 1);

    // Timeout after three idle seconds
    tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(4);
    tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(4);
    chk("tmo_two_ticks", state, 2);
    tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
    chk("tmo_state", state, 0);
    chk("tmo_run_en", run_en, 1);
    chk("tmo_blank_min", blank_min, 0);

    // MODE and INC together in SET_HOUR: MODE wins, no repeat
    press(0);
    chk("sim_pre", state, 1);
    n_hour0 = n_hour;
    n_min0  = n_min;
    btn_mode_n = 1'b0; btn_inc_n = 1'b0;
    step(7);
    chk("sim_state", state, 2);
    step(40);
    btn_mode_n = 1'b1; btn_inc_n = 1'b1;
    step(12);
    chk("sim_hour_cnt", n_hour, n_hour0);
    chk("sim_min_cnt", n_min, n_min0);
    press(1);
    chk("sim_repress", n_min, n_min0 + 1);

    // Reset while holding INC in SET_MIN
    btn_inc_n = 1'b0;
    step(10);
    chk("hold_min_inc", n_min, n_min0 + 2);
    reset = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_run_en", run_en, 1);
    step(2);
    reset = 1'b0;
    step(40);
    press(0);
    press(0);
    chk("post_rst_state", state, 2);
    chk("post_rst_min_cnt", n_min, n_min0 + 2);
    chk("post_rst_hour_cnt", n_hour, n_hour0);
    btn_inc_n = 1'b1;
    step(12);
    press(1);
    chk("post_rst_repress", n_min, n_min0 + 3);
    chk("multi_strobe", n_multi, 0);
    chk("sec_inc_never", n_secinc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-set sequencer for the 7-segment HH:MM:SS clock datapath.
- Debounces the raw KEY buttons and walks an FSM through RUN -> SET_HOUR -> SET_MIN -> SET_SEC.
- Gates the running count, issues single-cycle increment/clear strobes to the selected field counter, and drives per-field blink blanking.
- Sits between the board keys and the hour/minute/second counterN chain, beside the 1 Hz divider.

Parameters:
- DB_CYC, 1_000_000, consecutive stable clk50 cycles for a debounced level change (20 ms).
- RPT_DLY_CYC, 25_000_000, hold time before the first auto-repeat increment (0.5 s).
- RPT_CYC, 10_000_000, auto-repeat interval after the first repeat (0.2 s).
- BLINK_CYC, 12_500_000, clk50 cycles per blink phase (2 Hz toggle).
- TIMEOUT_TICKS, 30, tick_1hz pulses without a press event before returning to RUN.

Ports:
- clk50, input, 1, 50 MHz system clock.
- reset, input, 1, asynchronous, active-high.
- btn_mode_n, input, 1, raw KEY, active-low, asynchronous to clk50.
- btn_inc_n, input, 1, raw KEY, active-low, asynchronous to clk50.
- tick_1hz, input, 1, one-cycle pulse per second from the divider.
- run_en, output, 1, count-enable for the seconds counter; 1 only in RUN.
- sec_inc, output, 1, one-cycle increment strobe to the seconds field (unused; held 0, see SET_SEC).
- sec_clr, output, 1, one-cycle synchronous clear of the seconds field.
- min_inc, output, 1, one-cycle increment strobe to the minutes field (carry suppressed by datapath).
- hour_inc, output, 1, one-cycle increment strobe to the hours field.
- blank_hour, output, 1, blank both hour digits.
- blank_min, output, 1, blank both minute digits.
- blank_sec, output, 1, blank both second digits.
- state, output, 2, 0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.

Behaviour:
- Reset (async):
  - state=RUN, run_en=1, all strobes 0, all blanks 0.
  - Debounced levels = released; all counters cleared.
- Synchronisation and debounce:
  - Each button passes through a 2-FF synchroniser, then a per-button stability counter.
  - The debounced level updates only after DB_CYC consecutive equal synchronised samples.
  - Press event = one-cycle pulse on the debounced released->pressed edge. Release produces no event.
- FSM, on a mode press event:
  - RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
  - state and run_en update on the cycle after the event.
- Increments:
  - An inc press event in SET_HOUR or SET_MIN gives one hour_inc or min_inc pulse on the next cycle.
  - An inc press event in SET_SEC gives sec_clr instead.
  - In RUN, inc is ignored.
- Auto-repeat (SET_HOUR and SET_MIN only):
  - While inc stays debounced-pressed, one extra strobe after RPT_DLY_CYC.
  - Then one strobe every RPT_CYC.
  - Repeat counter clears on release, on any state change, and on reset.
- Strobes: never more than one strobe high in any cycle; each strobe is exactly one cycle wide.
- Simultaneous mode and inc events in the same cycle:
  - Mode wins; the inc event is discarded.
  - Repeat is cancelled until inc is released and pressed again.
- Timeout:
  - In any SET state, an idle counter increments on tick_1hz and clears on any press event or auto-repeat strobe.
  - Reaching TIMEOUT_TICKS forces RUN on the next cycle.
  - Timeout and a mode event in the same cycle -> RUN.
- Blink:
  - A phase counter runs only in SET states and toggles blink_phase every BLINK_CYC.
  - The selected field's blank = blink_phase; the other fields' blanks = 0.
  - blink_phase resets to 0 (visible) on every state entry and on every inc/clr strobe.
  - In RUN, all blanks = 0.
- Wrap-around: field modulo (24/60/60) is owned by the counters. This block never suppresses strobes at field limits.
- Reset mid-hold or mid-set: returns to RUN immediately. A button still held at release of reset produces no press event until it is released and pressed again.

Test Plan (DB_CYC=4, RPT_DLY_CYC=20, RPT_CYC=8, BLINK_CYC=6, TIMEOUT_TICKS=3):
- Reset, idle 50 cycles -> state=0, run_en=1, all strobes/blanks 0.
- Glitch btn_mode_n low for 3 cycles -> no state change. Low for 10 cycles -> state=1, run_en=0 within DB_CYC+4 cycles.
- State=1, hold inc 60 cycles -> hour_inc pulses at press+~6, +20, +28, +36, +44, +52 (6 total); release -> no further pulses.
- State=3, press inc -> exactly one sec_clr pulse, sec_inc/min_inc/hour_inc stay 0.
- State=2, no presses, 3 tick_1hz pulses -> state=0, run_en=1, blank_min=0. blank_min toggles every 6 cycles before the timeout.
- Mode and inc debounced-pressed in the same cycle in state=1 -> state=2, no hour_inc/min_inc until inc is re-pressed.
- Assert reset while in state=2 holding inc -> immediate state=0; holding inc through reset release yields no min_inc.
